// File: rtl/bsg_manycore_endpoint_req_arbiter.sv
// Round-robin arbiter feeding one endpoint request FIFO through a one-entry output register.
// Optional credit gating: define BSG_MANYCORE_ENDPOINT_REQ_ARBITER_CREDIT_GATE_EN.
`default_nettype none

module bsg_manycore_endpoint_req_arbiter #(
    parameter int num_req_p         = 4,
    parameter int fifo_width_p      = 128,
    parameter int max_out_credits_p = 32,
    parameter int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
    parameter int lg_num_req_lp     = $clog2(num_req_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*fifo_width_p-1:0]  req_data_i,
    output logic [num_req_p-1:0]               req_ready_o,
    output logic                               endpoint_req_v_o,
    output logic [fifo_width_p-1:0]            endpoint_req_data_o,
    input  logic                               endpoint_req_ready_i,
    input  logic [credit_counter_width_lp-1:0] out_credits_i,
    output logic [lg_num_req_lp-1:0]           grant_id_o
);

    logic                     out_v_r;
    logic [fifo_width_p-1:0]  out_data_r;
    logic [lg_num_req_lp-1:0] out_id_r;
    logic [lg_num_req_lp-1:0] last_grant_r;

    logic                     credit_ok;
    logic                     load_ok;
    logic                     any_v;
    logic [lg_num_req_lp-1:0] grant_idx;
    logic [fifo_width_p-1:0]  grant_data;
    logic                     handshake;

`ifdef BSG_MANYCORE_ENDPOINT_REQ_ARBITER_CREDIT_GATE_EN
    // One credit stays reserved for the packet already sitting in the output register.
    assign credit_ok = (out_credits_i > credit_counter_width_lp'(out_v_r));
`else
    logic unused_credits;
    assign unused_credits = ^out_credits_i;
    assign credit_ok      = 1'b1;
`endif

    assign load_ok = (~out_v_r | endpoint_req_ready_i) & credit_ok;

    always_comb begin
        int idx;
        any_v     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(last_grant_r) + 1 + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!any_v && req_v_i[idx]) begin
                any_v     = 1'b1;
                grant_idx = lg_num_req_lp'(idx);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant_idx == lg_num_req_lp'(k)) begin
                grant_data = req_data_i[k*fifo_width_p +: fifo_width_p];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (!reset_i && load_ok && any_v) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign handshake = |(req_v_i & req_ready_o);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_r      <= 1'b0;
            out_data_r   <= '0;
            out_id_r     <= '0;
            last_grant_r <= lg_num_req_lp'(num_req_p - 1);
        end else if (handshake) begin
            out_v_r      <= 1'b1;
            out_data_r   <= grant_data;
            out_id_r     <= grant_idx;
            last_grant_r <= grant_idx;
        end else if (out_v_r && endpoint_req_ready_i) begin
            out_v_r      <= 1'b0;
        end
    end

    assign endpoint_req_v_o    = out_v_r;
    assign endpoint_req_data_o = out_data_r;
    assign grant_id_o          = out_id_r;

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_endpoint_req_arbiter.sv
// Directed self-checking bench for bsg_manycore_endpoint_req_arbiter (num_req_p=4).
`default_nettype none

module tb_bsg_manycore_endpoint_req_arbiter;

    localparam int N  = 4;
    localparam int W  = 128;
    localparam int CW = $clog2(32 + 1);

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_v_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           endpoint_req_v_o;
    logic [W-1:0]   endpoint_req_data_o;
    logic           endpoint_req_ready_i;
    logic [CW-1:0]  out_credits_i;
    logic [1:0]     grant_id_o;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] d [N];

    bsg_manycore_endpoint_req_arbiter dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .req_v_i             (req_v_i),
        .req_data_i          (req_data_i),
        .req_ready_o         (req_ready_o),
        .endpoint_req_v_o    (endpoint_req_v_o),
        .endpoint_req_data_o (endpoint_req_data_o),
        .endpoint_req_ready_i(endpoint_req_ready_i),
        .out_credits_i       (out_credits_i),
        .grant_id_o          (grant_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input int id);
        check({tag, ".v"}, W'(endpoint_req_v_o), W'(v));
        if (v) begin
            check({tag, ".id"}, W'(grant_id_o), W'(id));
            check({tag, ".data"}, endpoint_req_data_o, d[id]);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            d[k] = {32'hCAFE_0000 + 32'(k), 64'h0, 32'h1000_0000 + 32'(k * 17)};
            req_data_i[k*W +: W] = d[k];
        end
        reset_i              = 1'b1;
        req_v_i              = '1;
        endpoint_req_ready_i = 1'b1;
        out_credits_i        = CW'(32);
        #2;

        // reset state
        tick();
        tick();
        check("rst.ready", W'(req_ready_o), W'(4'b0000));
        check("rst.v", W'(endpoint_req_v_o), '0);
        reset_i = 1'b0;
        req_v_i = '0;
        tick();
        check("idle.v", W'(endpoint_req_v_o), '0);
        check("idle.ready", W'(req_ready_o), '0);
        check("idle.id", W'(grant_id_o), '0);

        // round robin with all requesters valid
        req_v_i = 4'b1111;
        #1;
        check("rr.ready0", W'(req_ready_o), W'(4'b0001));
        tick();
        check_out("rr0", 1'b1, 0);
        check("rr.ready1", W'(req_ready_o), W'(4'b0010));
        tick();
        check_out("rr1", 1'b1, 1);
        check("rr.ready2", W'(req_ready_o), W'(4'b0100));
        tick();
        check_out("rr2", 1'b1, 2);
        check("rr.ready3", W'(req_ready_o), W'(4'b1000));
        tick();
        check_out("rr3", 1'b1, 3);
        check("rr.ready4", W'(req_ready_o), W'(4'b0001));
        tick();
        check_out("rr4", 1'b1, 0);
        req_v_i = '0;
        tick();
        check_out("drain", 1'b0, 0);

        // backpressure: last grant = 0, requester 2 alone
        req_v_i              = 4'b0100;
        endpoint_req_ready_i = 1'b0;
        #1;
        check("bp.ready1", W'(req_ready_o), W'(4'b0100));
        tick();
        for (int c = 2; c <= 5; c++) begin
            check("bp.readyN", W'(req_ready_o), '0);
            check_out("bp.hold", 1'b1, 2);
            if (c < 5) tick();
        end
        tick();
        req_v_i              = '0;
        endpoint_req_ready_i = 1'b1;
        #1;
        check_out("bp.deliver", 1'b1, 2);
        check("bp.ready_idle", W'(req_ready_o), '0);
        tick();
        check_out("bp.after", 1'b0, 0);

        // wrap: make last grant 3, then 1010 -> 1, 3
        req_v_i = 4'b1000;
        tick();
        check_out("wrap.pre", 1'b1, 3);
        req_v_i = 4'b1010;
        #1;
        check("wrap.ready1", W'(req_ready_o), W'(4'b0010));
        tick();
        check_out("wrap.g1", 1'b1, 1);
        check("wrap.ready3", W'(req_ready_o), W'(4'b1000));
        tick();
        check_out("wrap.g3", 1'b1, 3);

        // credit behaviour with out_v_r=1, ready=1, requester 1 valid
        req_v_i       = 4'b0010;
        out_credits_i = CW'(1);
        #1;
`ifdef BSG_MANYCORE_ENDPOINT_REQ_ARBITER_CREDIT_GATE_EN
        check("cred1.ready", W'(req_ready_o), '0);
        out_credits_i = CW'(2);
        #1;
        check("cred2.ready", W'(req_ready_o), W'(4'b0010));
`else
        check("cred1.ready", W'(req_ready_o), W'(4'b0010));
        out_credits_i = CW'(0);
        #1;
        check("cred0.ready", W'(req_ready_o), W'(4'b0010));
`endif
        tick();
        check_out("cred.load", 1'b1, 1);

        // reset mid-operation discards the held packet
        req_v_i              = '0;
        endpoint_req_ready_i = 1'b0;
        out_credits_i        = CW'(32);
        tick();
        check_out("mr.held", 1'b1, 1);
        reset_i = 1'b1;
        #1;
        check("mr.ready_in_rst", W'(req_ready_o), '0);
        tick();
        reset_i              = 1'b0;
        endpoint_req_ready_i = 1'b1;
        #1;
        check("mr.v0", W'(endpoint_req_v_o), '0);
        tick();
        check("mr.v1", W'(endpoint_req_v_o), '0);
        req_v_i = 4'b1111;
        #1;
        check("mr.prio0", W'(req_ready_o), W'(4'b0001));
        tick();
        check_out("mr.first", 1'b1, 0);
        req_v_i = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
